voq_sched: RTL

Parametrised scheduler for the shared-memory switch. Each cycle it matches input-port VOQs to memory banks, at most one pair per input and one per bank. It drives VOQ dequeue strobes and destination selects on the read side, and bank write strobes and mux selects on the write side. It generalises the fixed-rotation mux controller:

- port count is a module parameter instead of a global define;
- it adds a round-robin matching mode that skips empty VOQs and full banks;
- it adds an optional pipeline stage and a scheduling enable.

---
 rtl/voq_sched_pkg.sv | 32 +++
 rtl/voq_sched_rr_arbiter.sv | 35 +++
 rtl/voq_sched.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/voq_sched_pkg.sv
// Shared definitions for the VOQ-to-bank scheduler: select-field width,
// scheduling mode encodings and explicit modulo helpers for pointer wrap.
package voq_sched_pkg;

  localparam int SCHED_TDM = 0;
  localparam int SCHED_RR  = 1;

  // Width of one select field: clog2(n), but never less than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // (v + 1) mod n for 0 <= v < n.
  function automatic int mod_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

  // (a + b) mod n for 0 <= a, b < n.
  function automatic int mod_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

  // Forward distance from p to i around a ring of n slots.
  function automatic int mod_dist(input int i, input int p, input int n);
    return (i >= p) ? i - p : i + n - p;
  endfunction

endpackage

// File: rtl/voq_sched_rr_arbiter.sv
// Programmable-priority arbiter: grants the first set req bit found scanning
// upward from ptr with wrap. Purely combinational.
module rr_arbiter
  import voq_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         valid
);

  int best;

  // Smallest ring distance from ptr wins, which is the first hit of a wrapped scan.
  always_comb begin
    best  = N;
    idx   = '0;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (mod_dist(i, int'(ptr), N) < best)) begin
        best = mod_dist(i, int'(ptr), N);
        idx  = W'(i);
      end
    end
    valid = |req;
    for (int i = 0; i < N; i++) begin
      grant[i] = valid && (idx == W'(i));
    end
  end

endmodule

// File: rtl/voq_sched.sv
// Shared-memory switch scheduler: matches input VOQs to banks each cycle
// (fixed TDM rotation or single-iteration round-robin) and drives read/write strobes.
module voq_sched
  import voq_sched_pkg::*;
#(
  parameter int PORT_NUB = 4,
  parameter int MODE     = SCHED_RR,
  parameter int PIPELINE = 0,
  localparam int W       = sel_width(PORT_NUB)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [PORT_NUB*PORT_NUB-1:0]   empty_in,
  input  logic [PORT_NUB-1:0]            full_in,
  output logic [PORT_NUB-1:0]            rd_out,
  output logic [PORT_NUB*W-1:0]          rd_sel,
  output logic [PORT_NUB-1:0]            wr_out,
  output logic [PORT_NUB*W-1:0]          mux_sel
);

  localparam int N = PORT_NUB;

  logic [N-1:0][N-1:0] req;      // req[i][j]: input i wants bank j
  logic [N-1:0]        dec_rd;
  logic [N-1:0][W-1:0] dec_sel;
  logic [N-1:0]        s1_rd;
  logic [N-1:0][W-1:0] s1_sel;
  logic [N-1:0]        rd_q;
  logic [N-1:0][W-1:0] rd_sel_q;
  logic [N-1:0]        wr_nxt;
  logic [N-1:0][W-1:0] mux_nxt;
  logic [N-1:0][W-1:0] mux_q;

  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        req[i][j] = en & ~empty_in[i*N+j] & ~full_in[j];
      end
    end
  end

  if (MODE == SCHED_TDM) begin : g_tdm
    logic [W-1:0]        off;
    logic [N-1:0][W-1:0] tdm_dest;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  off <= '0;
      else if (en) off <= W'(mod_inc(int'(off), N));
    end

    always_comb begin
      dec_rd   = '0;
      dec_sel  = '0;
      tdm_dest = '0;
      for (int i = 0; i < N; i++) begin
        tdm_dest[i] = W'(mod_add(i, int'(off), N));
        for (int j = 0; j < N; j++) begin
          if (tdm_dest[i] == W'(j)) dec_rd[i] = req[i][j];
        end
        if (dec_rd[i]) dec_sel[i] = tdm_dest[i];
      end
    end
  end else begin : g_rr
    logic [N-1:0][W-1:0] gptr;
    logic [N-1:0][W-1:0] aptr;
    logic [N-1:0][N-1:0] g_req;  // per bank j, bit i
    logic [N-1:0][N-1:0] g_gnt;
    logic [N-1:0][W-1:0] g_idx;
    logic [N-1:0]        g_vld;
    logic [N-1:0][N-1:0] a_req;  // per input i, bit j
    logic [N-1:0][N-1:0] a_gnt;
    logic [N-1:0][W-1:0] a_idx;
    logic [N-1:0]        a_vld;
    logic                idx_unused;

    assign idx_unused = ^g_idx;

    always_comb begin
      g_req = '0;
      a_req = '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          g_req[j][i] = req[i][j];
          a_req[i][j] = g_vld[j] & g_gnt[j][i];
        end
      end
    end

    for (genvar j = 0; j < N; j++) begin : g_grant
      rr_arbiter #(.N(N), .W(W)) u_grant (
        .req(g_req[j]), .ptr(gptr[j]), .grant(g_gnt[j]), .idx(g_idx[j]), .valid(g_vld[j])
      );
    end

    for (genvar i = 0; i < N; i++) begin : g_accept
      rr_arbiter #(.N(N), .W(W)) u_accept (
        .req(a_req[i]), .ptr(aptr[i]), .grant(a_gnt[i]), .idx(a_idx[i]), .valid(a_vld[i])
      );
    end

    always_comb begin
      dec_rd  = a_vld;
      dec_sel = '0;
      for (int i = 0; i < N; i++) begin
        if (a_vld[i]) dec_sel[i] = a_idx[i];
      end
    end

    // Pointers move only past an accepted pair; with en=0 nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gptr <= '0;
        aptr <= '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (a_vld[i]) aptr[i] <= W'(mod_inc(int'(a_idx[i]), N));
          for (int j = 0; j < N; j++) begin
            if (a_gnt[i][j]) gptr[j] <= W'(mod_inc(i, N));
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rd  <= '0;
      s1_sel <= '0;
    end else begin
      s1_rd  <= dec_rd;
      s1_sel <= dec_sel;
    end
  end

  if (PIPELINE != 0) begin : g_pipe
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q     <= '0;
        rd_sel_q <= '0;
      end else begin
        rd_q     <= s1_rd;
        rd_sel_q <= s1_sel;
      end
    end
  end else begin : g_nopipe
    assign rd_q     = s1_rd;
    assign rd_sel_q = s1_sel;
  end

  // Invert the read-side match so each bank learns its source one cycle later.
  always_comb begin
    wr_nxt  = '0;
    mux_nxt = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if (rd_q[i] && (rd_sel_q[i] == W'(j))) begin
          wr_nxt[j]  = 1'b1;
          mux_nxt[j] = W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_out <= '0;
      mux_q  <= '0;
    end else begin
      wr_out <= wr_nxt;
      mux_q  <= mux_nxt;
    end
  end

  assign rd_out  = rd_q;
  assign rd_sel  = rd_sel_q;
  assign mux_sel = mux_q;

endmodule
